// File: rtl/ps2_receptor.sv
// PS/2 device-to-host receiver. Conditions the asynchronous PS/2 lines, detects filtered
// clock falling edges, shifts in an 11-bit frame and reports each valid scan code with a
// one-cycle strobe, or flags parity, stop-bit and inter-edge timeout failures.
`timescale 1ns / 1ps
module ps2_receptor #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] codigo,
  output logic       en,
  output logic       err,
  output logic       busy
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;

  state_e        state_q;
  logic [2:0]    bcnt_q;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [7:0]    codigo_q;
  logic          en_q, err_q;

  // Two-flop synchronizers; lines idle high so they reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: flip only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2_q != filt_q) begin
        if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= clk_s2_q;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  // Sample event: filtered clock went 1->0 on the previous edge.
  assign fall = filt_prev_q & ~filt_q;

  // Frame FSM with registered strobes; a sample event takes priority over a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      codigo_q <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      if (state_q == StIdle) begin
        tcnt_q <= '0;
        if (fall && !dat_s2_q) begin
          state_q <= StData;
          bcnt_q  <= '0;
        end
      end else if (fall) begin
        tcnt_q <= '0;
        if (state_q == StData) begin
          shift_q <= {dat_s2_q, shift_q[7:1]};
          if (bcnt_q == 3'd7) begin
            state_q <= StParity;
          end else begin
            bcnt_q <= bcnt_q + 3'd1;
          end
        end else if (state_q == StParity) begin
          par_q   <= dat_s2_q;
          state_q <= StStop;
        end else begin
          // Odd parity: data bits plus parity bit must contain an odd number of ones.
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            codigo_q <= shift_q;
            en_q     <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= StIdle;
        end
      end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_q   <= 1'b1;
        tcnt_q  <= '0;
        state_q <= StIdle;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign codigo = codigo_q;
  assign en     = en_q;
  assign err    = err_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_receptor.sv
// Self-checking bench for ps2_receptor: expected events are queued as frames are driven,
// a monitor collects observed en/err strobes, and each scenario task compares the two.
`timescale 1ns / 1ps
module tb_ps2_receptor;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] codigo;
  logic       en, err, busy;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    int         t;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         both_cnt = 0;
  int         cyc = 0;
  int         last_fall = 0;
  logic [7:0] model_code;

  ps2_receptor #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .codigo   (codigo),
    .en       (en),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect strobes away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (en && err) both_cnt <= both_cnt + 1;
      if (en) obs_q.push_back('{is_err: 1'b0, code: codigo, t: cyc});
      else if (err) obs_q.push_back('{is_err: 1'b1, code: codigo, t: cyc});
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk) ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic p;
    p = (~^d) ^ bad_par;
    if (!bad_par && !bad_stop) begin
      model_code = d;
      exp_q.push_back('{is_err: 1'b0, code: d, t: 0});
    end else begin
      exp_q.push_back('{is_err: 1'b1, code: model_code, t: 0});
    end
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(p, 1'b0);
    send_bit(~bad_stop, 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic check_events(input string name);
    ev_t e, o;
    repeat (50) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: no strobe seen, required err=%0b codigo=%02h", name, e.is_err, e.code);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.code !== e.code) begin
          miscompares++;
          $display("FAIL %s: got err=%0b codigo=%02h, required err=%0b codigo=%02h",
                   name, o.is_err, o.code, e.is_err, e.code);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected strobe err=%0b codigo=%02h, required none",
               name, o.is_err, o.code);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    vectors += 4;
    if (codigo !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_codigo: got %02h required 00", codigo);
    end
    if (en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_en: got %b required 0", en);
    end
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b required 0", err);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    reset = 1'b0;
    model_code = 8'h00;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_events("single_1c");
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_events("back_to_back");
  endtask

  task automatic test_bad_frames();
    send_frame(8'h29, 1'b1, 1'b0, 1'b0);
    check_events("bad_parity");
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_events("bad_stop");
  endtask

  task automatic test_glitch();
    repeat (50) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check_events("glitch_5a");
  endtask

  task automatic test_timeout();
    ev_t o;
    int  waited;
    exp_q.push_back('{is_err: 1'b1, code: model_code, t: 0});
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (1000) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_busy_mid: got %b required 1", busy);
    end
    waited = 0;
    while (obs_q.size() == 0 && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    void'(exp_q.pop_front());
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL timeout_err: no err strobe, required one near %0d cycles", TO);
    end else begin
      o = obs_q.pop_front();
      if (o.is_err !== 1'b1 || o.code !== model_code ||
          (o.t - last_fall) < TO || (o.t - last_fall) > TO + 20) begin
        miscompares++;
        $display("FAIL timeout_err: got err=%0b codigo=%02h delay=%0d, required err=1 %02h %0d..%0d",
                 o.is_err, o.code, o.t - last_fall, model_code, TO, TO + 20);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_busy_after: got %b required 0", busy);
    end
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_events("after_timeout_29");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h1C;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0);
    @(negedge clk) ps2_data = d[3];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    vectors += 4;
    if (codigo !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_codigo: got %02h required 00", codigo);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_busy: got %b required 0", busy);
    end
    if (en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_en: got %b required 0", en);
    end
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_err: got %b required 0", err);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    model_code = 8'h00;
    repeat (100) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got %0d strobes required 0", obs_q.size());
    end
    obs_q.delete();
    send_frame(8'h76, 1'b0, 1'b0, 1'b0);
    check_events("after_reset_76");
  endtask

  task automatic test_exclusive();
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL en_err_overlap: got %0d cycles required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
